// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Provides the datapath/register-address widths, the ALUOp encoding and the
// decoded-control bundle that travels down the pipeline as one unit.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // ALU operation class produced by the main decoder.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,  // address arithmetic for lw/sw
    ALU_SUB   = 2'b01,  // branch compare
    ALU_RTYPE = 2'b10,  // operation chosen by funct field
    ALU_IMM   = 2'b11   // immediate-class operation
  } alu_op_e;

  // Control bundle. A bubble is simply this struct set to all zeros.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector.
// Flags when the instruction in EX is a load whose destination is a register
// that the instruction in decode actually reads. A load into $0 never stalls.
// Ports:
//   ex_valid, ex_mem_read, ex_dest : the instruction currently held in EX
//   id_valid, id_rs, id_rt         : the instruction in decode
//   use_rs, use_rt                 : which source fields decode really reads
//   hz                             : hazard, one bubble is required
module load_use_detect
  import cpu_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  use_rs,
  input  logic                  use_rt,
  output logic                  hz
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = use_rs && (id_rs == ex_dest);
  assign rt_hit = use_rt && (id_rt == ex_dest);

  assign hz = ex_valid && ex_mem_read && (ex_dest != '0) && id_valid &&
              (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures operands, immediate and decoded control for one instruction per
// cycle, resolves the destination register, inserts a single bubble on a
// load-use hazard (stalling PC and IF/ID), honours a downstream hold and a
// branch/jump flush, and counts inserted bubbles with a saturating counter.
// Ports:
//   clk_i, rst_i                      : clock, async active-high reset
//   valid_i, *addr_i, use_r*_i        : decode instruction and its source usage
//   RSdata_i, RTdata_i, imm_i         : operands from register file / extender
//   RegWrite_i..RegDst_i, ALUOp_i     : decoded control
//   flush_i, stall_i                  : kill decode instruction / downstream hold
//   stall_o                           : hold PC and IF/ID this cycle
//   valid_o, *_o                      : registered EX-stage instruction
//   bubble_cnt_o                      : load-use bubbles inserted (saturating)
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] RSaddr_i,
  input  logic [REG_ADDR_W-1:0] RTaddr_i,
  input  logic [REG_ADDR_W-1:0] RDaddr_i,
  input  logic                  use_rs_i,
  input  logic                  use_rt_i,
  input  logic [DATA_W-1:0]     RSdata_i,
  input  logic [DATA_W-1:0]     RTdata_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic                  RegWrite_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic                  MemtoReg_i,
  input  logic                  ALUSrc_i,
  input  logic                  RegDst_i,
  input  logic [1:0]            ALUOp_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] RSaddr_o,
  output logic [REG_ADDR_W-1:0] RTaddr_o,
  output logic [REG_ADDR_W-1:0] dest_o,
  output logic [DATA_W-1:0]     RSdata_o,
  output logic [DATA_W-1:0]     RTdata_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic                  RegWrite_o,
  output logic                  MemRead_o,
  output logic                  MemWrite_o,
  output logic                  MemtoReg_o,
  output logic                  ALUSrc_o,
  output logic [1:0]            ALUOp_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs_addr_q;
  logic [REG_ADDR_W-1:0] rt_addr_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     rs_data_q;
  logic [DATA_W-1:0]     rt_data_q;
  logic [DATA_W-1:0]     imm_q;
  ctrl_t                 ctrl_q;
  logic [CNT_W-1:0]      bubble_cnt_q;

  ctrl_t                 in_ctrl;
  logic [REG_ADDR_W-1:0] in_dest;
  logic                  hz;

  load_use_detect u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_dest     (dest_q),
    .id_valid    (valid_i),
    .id_rs       (RSaddr_i),
    .id_rt       (RTaddr_i),
    .use_rs      (use_rs_i),
    .use_rt      (use_rt_i),
    .hz          (hz)
  );

  // A flush kills the consumer, so there is no point holding IF/ID for it.
  assign stall_o = stall_i || (hz && !flush_i);

  assign in_dest = RegDst_i ? RDaddr_i : RTaddr_i;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_ctrl = '0;
    if (valid_i) begin
      in_ctrl.reg_write  = RegWrite_i;
      in_ctrl.mem_read   = MemRead_i;
      in_ctrl.mem_write  = MemWrite_i;
      in_ctrl.mem_to_reg = MemtoReg_i;
      in_ctrl.alu_src    = ALUSrc_i;
      in_ctrl.alu_op     = alu_op_e'(ALUOp_i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      dest_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else if (flush_i || (!stall_i && hz)) begin
      // Bubble: the whole control bundle and destination go to zero at once.
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      dest_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      // Only hazard bubbles are counted; flush bubbles are branch cost.
      if (!flush_i && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end else if (!stall_i) begin
      valid_q   <= valid_i;
      rs_addr_q <= RSaddr_i;
      rt_addr_q <= RTaddr_i;
      dest_q    <= in_dest;
      rs_data_q <= RSdata_i;
      rt_data_q <= RTdata_i;
      imm_q     <= imm_i;
      ctrl_q    <= in_ctrl;
    end
  end

  assign valid_o      = valid_q;
  assign RSaddr_o     = rs_addr_q;
  assign RTaddr_o     = rt_addr_q;
  assign dest_o       = dest_q;
  assign RSdata_o     = rs_data_q;
  assign RTdata_o     = rt_data_q;
  assign imm_o        = imm_q;
  assign RegWrite_o   = ctrl_q.reg_write;
  assign MemRead_o    = ctrl_q.mem_read;
  assign MemWrite_o   = ctrl_q.mem_write;
  assign MemtoReg_o   = ctrl_q.mem_to_reg;
  assign ALUSrc_o     = ctrl_q.alu_src;
  assign ALUOp_o      = ctrl_q.alu_op;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
